// File: rtl/rsa_pkg.sv
// Shared state encoding, widths and helpers for the RSA exponentiation arbiter.
package rsa_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int ENG_T_WIDTH    = 5;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t IDLE    = 3'd0;
    localparam arb_state_t ENG_RST = 3'd1;
    localparam arb_state_t START   = 3'd2;
    localparam arb_state_t WAIT    = 3'd3;
    localparam arb_state_t RESP    = 3'd4;

    // Engine exponent-length field saturates at 31 for wide operands.
    function automatic logic [ENG_T_WIDTH-1:0] clamp_t(input int idx);
        return (idx > 31) ? 5'd31 : ENG_T_WIDTH'(idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: searches req starting one past ptr, returns one-hot grant and its index.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDXW-1:0] gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IDXW'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/montgomery_exp_arbiter.sv
// Shares one montgomery_exp engine among NREQ requesters: round-robin accept,
// engine sequencing (reset, enable, wait done / timeout) and a valid/ready response.
//
// state   | meaning
// IDLE    | offering req_ready to the round-robin pick
// ENG_RST | one-cycle engine reset pulse
// START   | one-cycle engine enable pulse, timer cleared
// WAIT    | waiting for eng_done or timeout
// RESP    | result held on resp_* until the granted requester takes it
module montgomery_exp_arbiter
    import rsa_pkg::*;
#(
    parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*WORD_WIDTH-1:0] req_x,
    input  logic [NREQ*WORD_WIDTH-1:0] req_e,
    input  logic [NREQ*WORD_WIDTH-1:0] req_m,
    output logic [NREQ-1:0]            resp_valid,
    input  logic [NREQ-1:0]            resp_ready,
    output logic [WORD_WIDTH-1:0]      resp_result,
    output logic                       resp_err,
    output logic                       busy,
    output logic                       eng_reset,
    output logic                       eng_enable,
    output logic [WORD_WIDTH-1:0]      eng_x,
    output logic [WORD_WIDTH-1:0]      eng_e,
    output logic [WORD_WIDTH-1:0]      eng_m,
    output logic [ENG_T_WIDTH-1:0]     eng_t,
    output logic [WORD_WIDTH:0]        eng_R,
    input  logic                       eng_done,
    input  logic [WORD_WIDTH-1:0]      eng_result
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    arb_state_t            state_q, state_d;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]       gnt_q, gnt_d;
    logic [WORD_WIDTH-1:0] x_q, x_d, e_q, e_d, m_q, m_d;
    logic [WORD_WIDTH-1:0] result_q, result_d;
    logic                  err_q, err_d;
    logic [TW-1:0]         timer_q, timer_d;

    logic [NREQ-1:0]       arb_gnt;
    logic [IDXW-1:0]       arb_idx;
    logic [WORD_WIDTH-1:0] sel_x, sel_e, sel_m;

    rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_comb begin
        sel_x = '0;
        sel_e = '0;
        sel_m = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_x = req_x[i*WORD_WIDTH +: WORD_WIDTH];
                sel_e = req_e[i*WORD_WIDTH +: WORD_WIDTH];
                sel_m = req_m[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        x_d      = x_q;
        e_d      = e_q;
        m_d      = m_q;
        result_d = result_q;
        err_d    = err_q;
        timer_d  = timer_q;
        case (state_q)
            IDLE: begin
                if (|(req_valid & arb_gnt)) begin
                    x_d      = sel_x;
                    e_d      = sel_e;
                    m_d      = sel_m;
                    gnt_d    = arb_idx;
                    rr_ptr_d = arb_idx;
                    // Even modulus and zero exponent are answered without the engine.
                    if (!sel_m[0]) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else if (sel_e == '0) begin
                        result_d = (sel_m == WORD_WIDTH'(1)) ? '0 : WORD_WIDTH'(1);
                        err_d    = 1'b0;
                        state_d  = RESP;
                    end else begin
                        err_d    = 1'b0;
                        state_d  = ENG_RST;
                    end
                end
            end
            ENG_RST: state_d = START;
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer_q == TMAX) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (|(resp_ready & resp_valid)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDXW'(NREQ - 1);
            gnt_q    <= '0;
            x_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            x_q      <= x_d;
            e_q      <= e_d;
            m_q      <= m_d;
            result_q <= result_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        eng_t = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (e_q[i]) eng_t = clamp_t(i);
        end
    end

    assign req_ready   = (state_q == IDLE) ? arb_gnt : '0;
    assign resp_valid  = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
    assign resp_result = result_q;
    assign resp_err    = err_q;
    assign busy        = (state_q != IDLE);
    assign eng_reset   = (state_q == ENG_RST);
    assign eng_enable  = (state_q == START);
    assign eng_x       = x_q;
    assign eng_e       = e_q;
    assign eng_m       = m_q;
    assign eng_R       = {1'b1, {WORD_WIDTH{1'b0}}};

endmodule

// File: tb/tb_montgomery_exp_arbiter.sv
// Directed bench for montgomery_exp_arbiter with a behavioural engine (optionally stalled).
module tb_montgomery_exp_arbiter;

    localparam int W = 32;
    localparam int N = 2;
    localparam int T = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic [N*W-1:0] req_x, req_e, req_m;
    logic [W-1:0]   resp_result, eng_x, eng_e, eng_m;
    logic           resp_err, busy, eng_reset, eng_enable;
    logic [4:0]     eng_t;
    logic [W:0]     eng_R;
    logic           eng_done   = 1'b0;
    logic [W-1:0]   eng_result = '0;

    typedef struct {
        int         idx;
        logic [W-1:0] res;
        logic       err;
    } exp_t;
    exp_t sb[$];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  stub  = 1'b0;
    int  cnt   = 0;
    bit  running = 1'b0;
    int  en_count = 0;

    montgomery_exp_arbiter #(.WORD_WIDTH(W), .NREQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_e(req_e), .req_m(req_m),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_err(resp_err), .busy(busy),
        .eng_reset(eng_reset), .eng_enable(eng_enable),
        .eng_x(eng_x), .eng_e(eng_e), .eng_m(eng_m),
        .eng_t(eng_t), .eng_R(eng_R),
        .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] x, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [63:0] r, b;
        r = 64'(1) % 64'(m);
        b = 64'(x) % 64'(m);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * b) % 64'(m);
            b = (b * b) % 64'(m);
        end
        return r[W-1:0];
    endfunction

    // Engine stand-in: done rises four cycles after enable unless stalled.
    always @(posedge clk) begin
        if (eng_enable) en_count <= en_count + 1;
        if (eng_reset) begin
            eng_done <= 1'b0;
            running  <= 1'b0;
        end else if (eng_enable) begin
            running <= 1'b1;
            cnt     <= 3;
        end else if (running && !stub) begin
            if (cnt == 0) begin
                eng_done   <= 1'b1;
                eng_result <= modexp(eng_x, eng_e, eng_m);
                running    <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] put(input logic [N*W-1:0] v, input int idx,
                                           input logic [W-1:0] x);
        logic [N*W-1:0] mask, val;
        mask = {{(N-1)*W{1'b0}}, {W{1'b1}}} << (idx * W);
        val  = {{(N-1)*W{1'b0}}, x} << (idx * W);
        return (v & ~mask) | val;
    endfunction

    task automatic offer(input int idx, input logic [W-1:0] x, input logic [W-1:0] e,
                         input logic [W-1:0] m);
        req_x     = put(req_x, idx, x);
        req_e     = put(req_e, idx, e);
        req_m     = put(req_m, idx, m);
        req_valid = req_valid | (N'(1) << idx);
    endtask

    // Leaves the bench at the first cycle after the accept edge.
    task automatic send(input int idx, input logic [W-1:0] x, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] res, input logic err);
        exp_t ex;
        int   n;
        offer(idx, x, e, m);
        #1;
        n = 0;
        while (!req_ready[idx] && n < 50) begin
            tick();
            n++;
        end
        chk("req_ready_grant", req_ready, N'(1) << idx);
        ex.idx = idx;
        ex.res = res;
        ex.err = err;
        sb.push_back(ex);
        tick();
        req_valid = req_valid & ~(N'(1) << idx);
    endtask

    task automatic collect();
        exp_t         ex;
        int           n;
        logic [N-1:0] oh;
        n = 0;
        while (resp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        chk("resp_wait_bound", n < 200, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            ex = sb.pop_front();
            oh = N'(1) << ex.idx;
            chk("resp_valid", resp_valid, oh);
            chk("resp_result", resp_result, ex.res);
            chk("resp_err", resp_err, ex.err);
            resp_ready = oh;
            tick();
            resp_ready = '0;
            chk("resp_valid_drop", resp_valid, 0);
        end
    endtask

    task automatic check_quiet();
        chk("q_busy", busy, 0);
        chk("q_req_ready", req_ready, 0);
        chk("q_resp_valid", resp_valid, 0);
        chk("q_resp_result", resp_result, 0);
        chk("q_resp_err", resp_err, 0);
        chk("q_eng_reset", eng_reset, 0);
        chk("q_eng_enable", eng_enable, 0);
        chk("q_eng_x", eng_x, 0);
        chk("q_eng_e", eng_e, 0);
        chk("q_eng_m", eng_m, 0);
        chk("q_eng_t", eng_t, 0);
        chk("q_eng_R", eng_R, 64'h1_0000_0000);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int en_before;
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = '0;
        req_x      = '0;
        req_e      = '0;
        req_m      = '0;
        #3;
        check_quiet();
        tick();
        reset = 1'b1;

        // 1: single job with cycle-exact engine sequencing
        send(0, 5, 3, 7, 6, 0);
        chk("t1_eng_reset_c1", eng_reset, 1);
        chk("t1_eng_enable_c1", eng_enable, 0);
        chk("t1_busy", busy, 1);
        chk("t1_req_ready_busy", req_ready, 0);
        tick();
        chk("t1_eng_enable_c2", eng_enable, 1);
        chk("t1_eng_reset_c2", eng_reset, 0);
        chk("t1_eng_x", eng_x, 5);
        chk("t1_eng_e", eng_e, 3);
        chk("t1_eng_m", eng_m, 7);
        chk("t1_eng_t", eng_t, 1);
        tick();
        chk("t1_eng_enable_c3", eng_enable, 0);
        n = 0;
        while (!eng_done && n < 50) begin
            tick();
            n++;
        end
        chk("t1_done_bound", n < 50, 1);
        chk("t1_resp_at_D", resp_valid, 0);
        tick();
        chk("t1_resp_at_D1", resp_valid, 2'b01);
        collect();

        // 2: both requesting from reset, pointer starts at NREQ-1 so req0 goes first
        do_reset();
        offer(1, 2, 10, 1001);
        send(0, 4, 13, 497, 445, 0);
        collect();
        send(1, 2, 10, 1001, 23, 0);
        collect();
        offer(1, 2, 10, 1001);
        send(0, 4, 13, 497, 445, 0);
        collect();
        send(1, 2, 10, 1001, 23, 0);
        collect();

        // 3: jobs answered without the engine
        en_before = en_count;
        send(0, 9, 0, 7, 1, 0);
        chk("t3_resp_c1", resp_valid, 2'b01);
        chk("t3_no_enable", eng_enable, 0);
        collect();
        send(1, 9, 0, 1, 0, 0);
        collect();
        send(0, 9, 5, 10, 0, 1);
        chk("t3_even_resp_c1", resp_valid, 2'b01);
        collect();
        chk("t3_enable_count", en_count, en_before);

        // 4: engine stalls, job times out after T cycles in WAIT
        stub = 1'b1;
        send(0, 3, 32'h8000_0001, 11, 0, 1);
        tick();
        chk("t4_enable", eng_enable, 1);
        chk("t4_eng_t_clamp", eng_t, 31);
        n = 0;
        do begin
            tick();
            n++;
        end while (resp_valid == '0 && n < 100);
        chk("t4_timeout_latency", n, T + 1);
        collect();
        stub = 1'b0;
        send(1, 7, 2, 13, 10, 0);
        collect();

        // 5: response held while requester stalls; other requester's ready ignored
        send(0, 6, 5, 23, 2, 0);
        offer(1, 9, 3, 31);
        resp_ready = 2'b10;
        n = 0;
        while (resp_valid == '0 && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            chk("t5_hold_valid", resp_valid, 2'b01);
            chk("t5_hold_result", resp_result, 2);
            chk("t5_hold_err", resp_err, 0);
            chk("t5_hold_req_ready", req_ready, 0);
            chk("t5_hold_busy", busy, 1);
            tick();
        end
        resp_ready = '0;
        collect();
        send(1, 9, 3, 31, 16, 0);
        collect();

        // 6: reset during WAIT, then a fresh job
        send(0, 5, 3, 7, 6, 0);
        tick();
        tick();
        tick();
        chk("t6_busy_in_wait", busy, 1);
        reset = 1'b0;
        #1;
        check_quiet();
        tick();
        check_quiet();
        sb.delete();
        reset = 1'b1;
        send(1, 4, 13, 497, 445, 0);
        tick();
        chk("t6_eng_t", eng_t, 3);
        collect();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
